// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES output serializer.
package aes_pkg;

    localparam int unsigned WORDS_PER_BLOCK = 4;
    localparam int unsigned WORD_W          = 32;
    localparam int unsigned BLOCK_W         = WORDS_PER_BLOCK * WORD_W;
    localparam int unsigned BEAT_W          = $clog2(WORDS_PER_BLOCK);

    typedef logic [127:0] block_t;
    typedef logic [31:0]  word_t;

    // Beat index to word, most significant word first.
    function automatic word_t block_word(input block_t blk, input logic [BEAT_W-1:0] idx);
        word_t w;
        case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            default: w = blk[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/aes_block_fifo.sv
// Block FIFO: storage, head/tail pointers and occupancy level.
// AES_OUT_CLEAR_EN: popped entries are zeroed and reset clears all storage.
module aes_block_fifo
    import aes_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  block_t                   wdata,
    output block_t                   rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    block_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            wr_en;
    logic            rd_en;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign rd_en = !rst && pop && !empty;
    assign wr_en = !rst && push && (!full || rd_en);
    assign rdata = mem[rd_ptr];

    // Pointers and level; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

`ifdef AES_OUT_CLEAR_EN
    // Storage with scrubbing; a write into the just-freed slot wins over the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else begin
            if (rd_en) mem[rd_ptr] <= '0;
            if (wr_en) mem[wr_ptr] <= wdata;
        end
    end
`else
    // Plain storage, contents are left stale after pop.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end
`endif

endmodule

// File: rtl/aes_out_serializer.sv
// Serializes 128-bit ciphertext blocks into 32-bit beats, MSW first, with
// a halt request to the engine and a sticky overflow flag for dropped blocks.
// AES_OUT_CLEAR_EN: storage scrubbing and m_data forced to zero when idle.
module aes_out_serializer
    import aes_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HALT_MARGIN = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [127:0]             eng_out,
    input  logic                     eng_out_valid,
    output logic                     halt,
    output logic [31:0]              m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_last,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    block_t              head;
    logic                full;
    logic                empty;
    logic [BEAT_W-1:0]   beat;
    logic                handshake;
    logic                pop;
    word_t               head_word;

    aes_block_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (eng_out_valid),
        .pop   (pop),
        .wdata (eng_out),
        .rdata (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    assign m_valid   = !empty;
    assign handshake = m_valid && m_ready;
    assign pop       = handshake && (beat == BEAT_W'(WORDS_PER_BLOCK - 1));
    assign m_last    = m_valid && (beat == BEAT_W'(WORDS_PER_BLOCK - 1));
    // Decoded from the registered level only, so the engine sees no input path.
    assign halt      = (LW'(DEPTH) - level) <= LW'(HALT_MARGIN);

    // Select the current beat of the head block.
    always_comb begin
        head_word = block_word(head, beat);
`ifdef AES_OUT_CLEAR_EN
        m_data    = m_valid ? head_word : '0;
`else
        m_data    = head_word;
`endif
    end

    // Beat counter advances per handshake and wraps after the last word.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat <= '0;
        end else if (handshake) begin
            beat <= beat + BEAT_W'(1);
        end
    end

    // Sticky overflow: a push into a full FIFO with no pop on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (eng_out_valid && full && !pop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_aes_out_serializer.sv
// Randomized and directed bench for aes_out_serializer against a queue model.
module tb_aes_out_serializer;
    import aes_pkg::*;

    localparam int unsigned DEPTH       = 4;
    localparam int unsigned HALT_MARGIN = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [127:0]  eng_out;
    logic          eng_out_valid;
    logic          halt;
    logic [31:0]   m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic [2:0]    level;
    logic          overflow;

    aes_out_serializer #(
        .DEPTH       (DEPTH),
        .HALT_MARGIN (HALT_MARGIN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .eng_out       (eng_out),
        .eng_out_valid (eng_out_valid),
        .halt          (halt),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last        (m_last),
        .level         (level),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue of whole blocks, current beat, sticky overflow.
    block_t mq[$];
    int     m_beat   = 0;
    bit     m_ovf    = 1'b0;
    bit     check_en = 1'b0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input block_t b, input int idx);
        return 32'(b >> (32 * (3 - idx)));
    endfunction

    task automatic check_outputs();
        int   lvl;
        block_t hb;
        lvl = mq.size();
        check_eq("level",    128'(level),    128'(lvl));
        check_eq("m_valid",  128'(m_valid),  128'(lvl != 0));
        check_eq("m_last",   128'(m_last),   128'((lvl != 0) && (m_beat == 3)));
        check_eq("halt",     128'(halt),     128'((int'(DEPTH) - lvl) <= int'(HALT_MARGIN)));
        check_eq("overflow", 128'(overflow), 128'(m_ovf));
        if (lvl != 0) begin
            hb = mq[0];
            check_eq("m_data", 128'(m_data), 128'(model_word(hb, m_beat)));
        end
`ifdef AES_OUT_CLEAR_EN
        else check_eq("m_data_idle", 128'(m_data), 128'(0));
`endif
    endtask

    task automatic model_update(input bit v, input block_t d, input bit rdy, input bit r);
        bit hs;
        bit pp;
        bit acc;
        if (r) begin
            mq.delete();
            m_beat   = 0;
            m_ovf    = 1'b0;
            check_en = 1'b1;
        end else begin
            hs  = (mq.size() != 0) && rdy;
            pp  = hs && (m_beat == 3);
            acc = v && ((mq.size() < int'(DEPTH)) || pp);
            if (v && !acc) m_ovf = 1'b1;
            if (hs) m_beat = (m_beat + 1) % 4;
            if (pp) void'(mq.pop_front());
            if (acc) mq.push_back(d);
        end
    endtask

    // One clock: check outputs, drive inputs, take the edge, update the model.
    task automatic cycle(input bit v, input block_t d, input bit rdy, input bit r);
        @(negedge clk);
        if (check_en) check_outputs();
        rst           = r;
        eng_out_valid = v;
        eng_out       = d;
        m_ready       = rdy;
        @(posedge clk);
        model_update(v, d, rdy, r);
    endtask

    function automatic block_t rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    block_t blk0;
    block_t nb;
    localparam block_t KNOWN = 128'h00112233445566778899aabbccddeeff;

    initial begin
        rst = 1'b1; eng_out_valid = 1'b0; eng_out = '0; m_ready = 1'b0;

        // Reset with a push held high.
        cycle(1'b1, rand_block(), 1'b0, 1'b1);
        cycle(1'b1, rand_block(), 1'b0, 1'b1);
        #1;
        check_eq("rst_level",    128'(level),    128'(0));
        check_eq("rst_halt",     128'(halt),     128'(0));
        check_eq("rst_m_valid",  128'(m_valid),  128'(0));
        check_eq("rst_overflow", 128'(overflow), 128'(0));

        // Single known block with a ready sink.
        cycle(1'b1, KNOWN, 1'b1, 1'b0);
        #1; check_eq("beat0", 128'(m_data), 128'(32'h00112233));
            check_eq("last0", 128'(m_last), 128'(0));
        cycle(1'b0, '0, 1'b1, 1'b0);
        #1; check_eq("beat1", 128'(m_data), 128'(32'h44556677));
        cycle(1'b0, '0, 1'b1, 1'b0);
        #1; check_eq("beat2", 128'(m_data), 128'(32'h8899aabb));
            check_eq("last2", 128'(m_last), 128'(0));
        cycle(1'b0, '0, 1'b1, 1'b0);
        #1; check_eq("beat3", 128'(m_data), 128'(32'hccddeeff));
            check_eq("last3", 128'(m_last), 128'(1));
        cycle(1'b0, '0, 1'b1, 1'b0);
        #1; check_eq("drained", 128'(m_valid), 128'(0));

        // Backpressure fill and overflow.
        blk0 = rand_block();
        cycle(1'b1, blk0, 1'b0, 1'b0);
        cycle(1'b1, rand_block(), 1'b0, 1'b0);
        #1; check_eq("halt_at2", 128'(halt), 128'(1));
        cycle(1'b1, rand_block(), 1'b0, 1'b0);
        cycle(1'b1, rand_block(), 1'b0, 1'b0);
        #1; check_eq("full_level", 128'(level), 128'(4));
        cycle(1'b1, rand_block(), 1'b0, 1'b0);
        #1; check_eq("ovf_set",   128'(overflow), 128'(1));
            check_eq("ovf_level", 128'(level),    128'(4));
            check_eq("ovf_head",  128'(m_data),   128'(blk0[127:96]));

        // Full FIFO with a push on the beat-3 handshake.
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, rand_block(), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        nb = rand_block();
        cycle(1'b1, nb, 1'b1, 1'b0);
        #1; check_eq("simul_level", 128'(level),    128'(4));
            check_eq("simul_ovf",   128'(overflow), 128'(0));
        for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        #1; check_eq("nb_head", 128'(m_data), 128'(nb[127:96]));
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);

        // Alternating ready during a block.
        cycle(1'b1, rand_block(), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'(i % 2), 1'b0);

        // Reset in the middle of a block, then a fresh block starts at beat 0.
        cycle(1'b1, rand_block(), 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b1, KNOWN, 1'b0, 1'b0);
        #1; check_eq("post_rst_beat0", 128'(m_data), 128'(32'h00112233));
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, 1'b0);

        // Random traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 2) != 0), rand_block(),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 299) == 0));
        end
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
